// File: rtl/vend_sound_if.sv
// vend_sound_if: request/status bundle between the vending controller and the
// sound scheduler. The controller side drives req/mute; the scheduler drives
// the audio and status outputs.
interface vend_sound_if;
    logic [3:0] req;        // [3]=error, [2]=vend, [1]=change, [0]=coin pulses
    logic       mute;       // forces audio_out low, scheduling untouched
    logic       audio_out;  // square-wave drive to the PWM amplifier
    logic       busy;       // scheduler is in PLAY or GAP
    logic [1:0] active_id;  // sound in PLAY/GAP, 0 when idle
    logic [3:0] pending;    // latched requests not yet granted

    modport master (
        output req,
        output mute,
        input  audio_out,
        input  busy,
        input  active_id,
        input  pending
    );

    modport slave (
        input  req,
        input  mute,
        output audio_out,
        output busy,
        output active_id,
        output pending
    );
endinterface

// File: rtl/vend_sound_scheduler.sv
// vend_sound_scheduler: latches one-cycle sound requests, plays them one at a
// time by fixed priority (error > vend > change > coin) as a square wave of
// fixed duration, and inserts a silent gap plus one idle cycle between sounds.
// Optional macro SOUND_PREEMPT_EN: a pending error request aborts any other
// sound in PLAY or GAP and starts immediately.
module vend_sound_scheduler #(
    parameter int MS_CYCLES = 100_000,  // clk cycles per 1 ms duration tick
    parameter int TONE_TICK = 2_500,    // clk cycles per tone tick
    parameter int GAP_MS    = 20        // silent gap after each sound, ms
) (
    input  logic         clk,
    input  logic         rst_n,
    vend_sound_if.slave  bus
);

    // Durations are counted as whole ms (prescaler + ms counter) so neither
    // counter has to hold the full duration*MS_CYCLES product.
    localparam int MAX_MS = (GAP_MS > 300) ? GAP_MS : 300;
    localparam int MS_W   = $clog2(MS_CYCLES + 1);
    localparam int MSC_W  = $clog2(MAX_MS + 1);
    localparam int TONE_W = $clog2(80 * TONE_TICK + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         pending_q, pending_d;
    logic [1:0]         active_q, active_d;
    logic               audio_q, audio_d;
    logic [MS_W-1:0]    ms_pre_q, ms_pre_d;
    logic [MSC_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [TONE_W-1:0]  tone_q, tone_d;

    logic [3:0]         pend_merge;
    logic [1:0]         grant_id;
    logic [MSC_W-1:0]   dur_ms;
    logic [TONE_W-1:0]  half_ticks;
    logic               ms_tick;
    logic               play_end;
    logic               gap_end;
    logic               tone_tc;
    logic               start;
    logic [1:0]         start_id;

    // New requests merge into the latched set; repeats of a set bit are absorbed.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign pend_merge[gi] = pending_q[gi] | bus.req[gi];
        end
    endgenerate

    // Highest set pending index wins arbitration.
    always_comb begin
        grant_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) begin
                grant_id = 2'(i);
            end
        end
    end

    // Fixed sound table: duration in ms and half-period in clk cycles.
    always_comb begin
        dur_ms     = MSC_W'(50);
        half_ticks = TONE_W'(10 * TONE_TICK);
        case (active_q)
            2'd3: begin
                dur_ms     = MSC_W'(300);
                half_ticks = TONE_W'(80 * TONE_TICK);
            end
            2'd2: begin
                dur_ms     = MSC_W'(200);
                half_ticks = TONE_W'(20 * TONE_TICK);
            end
            2'd1: begin
                dur_ms     = MSC_W'(150);
                half_ticks = TONE_W'(25 * TONE_TICK);
            end
            default: begin
                dur_ms     = MSC_W'(50);
                half_ticks = TONE_W'(10 * TONE_TICK);
            end
        endcase
    end

    assign ms_tick  = (ms_pre_q == MS_W'(MS_CYCLES - 1));
    assign play_end = ms_tick && (ms_cnt_q == dur_ms - MSC_W'(1));
    assign gap_end  = ms_tick && (ms_cnt_q == MSC_W'(GAP_MS - 1));
    assign tone_tc  = (tone_q == half_ticks - TONE_W'(1));

    // Next-state, counter and output logic for IDLE/PLAY/GAP sequencing.
    always_comb begin
        state_d   = state_q;
        pending_d = pend_merge;
        active_d  = active_q;
        audio_d   = audio_q;
        ms_pre_d  = ms_tick ? '0 : ms_pre_q + MS_W'(1);
        ms_cnt_d  = ms_tick ? ms_cnt_q + MSC_W'(1) : ms_cnt_q;
        tone_d    = tone_tc ? '0 : tone_q + TONE_W'(1);
        start     = 1'b0;
        start_id  = grant_id;

        case (state_q)
            S_IDLE: begin
                ms_pre_d = '0;
                ms_cnt_d = '0;
                tone_d   = '0;
                audio_d  = 1'b0;
                active_d = 2'd0;
                if (pending_q != 4'd0) begin
                    start    = 1'b1;
                    start_id = grant_id;
                end
            end
            S_PLAY: begin
                if (tone_tc) begin
                    audio_d = ~audio_q;
                end
                if (play_end) begin
                    state_d  = S_GAP;
                    ms_pre_d = '0;
                    ms_cnt_d = '0;
                    tone_d   = '0;
                    audio_d  = 1'b0;
                end
            end
            S_GAP: begin
                audio_d = 1'b0;
                tone_d  = '0;
                if (gap_end) begin
                    state_d  = S_IDLE;
                    ms_pre_d = '0;
                    ms_cnt_d = '0;
                    active_d = 2'd0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ms_pre_d = '0;
                ms_cnt_d = '0;
                tone_d   = '0;
                audio_d  = 1'b0;
                active_d = 2'd0;
            end
        endcase

`ifdef SOUND_PREEMPT_EN
        // A pending error cuts off any other sound, including its gap.
        if ((state_q != S_IDLE) && pending_q[3] && (active_q != 2'd3)) begin
            start    = 1'b1;
            start_id = 2'd3;
        end
`endif

        // Starting a sound: restart all counters, first PLAY cycle drives high.
        // A same-cycle request for the granted bit keeps it pending.
        if (start) begin
            state_d             = S_PLAY;
            active_d            = start_id;
            pending_d[start_id] = bus.req[start_id];
            audio_d             = 1'b1;
            ms_pre_d            = '0;
            ms_cnt_d            = '0;
            tone_d              = '0;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            audio_q   <= 1'b0;
            ms_pre_q  <= '0;
            ms_cnt_q  <= '0;
            tone_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            audio_q   <= audio_d;
            ms_pre_q  <= ms_pre_d;
            ms_cnt_q  <= ms_cnt_d;
            tone_q    <= tone_d;
        end
    end

    assign bus.audio_out = audio_q & ~bus.mute;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.active_id = active_q;
    assign bus.pending   = pending_q;

endmodule
